// File: rtl/prbs_pkg.sv
// Shared PRBS checker definitions: polynomial select codes, order/tap lookup,
// LFSR width and sync FSM state encoding.
package prbs_pkg;

  localparam int LFSR_W = 31;

  localparam logic [3:0] PN7  = 4'd0;
  localparam logic [3:0] PN9  = 4'd1;
  localparam logic [3:0] PN11 = 4'd2;
  localparam logic [3:0] PN15 = 4'd3;
  localparam logic [3:0] PN20 = 4'd4;
  localparam logic [3:0] PN23 = 4'd5;
  localparam logic [3:0] PN31 = 4'd6;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_e;

  // Polynomial order n; unused select codes fall back to PN7.
  function automatic logic [4:0] pn_order(input logic [3:0] sel);
    case (sel)
      PN9:     return 5'd9;
      PN11:    return 5'd11;
      PN15:    return 5'd15;
      PN20:    return 5'd20;
      PN23:    return 5'd23;
      PN31:    return 5'd31;
      default: return 5'd7;
    endcase
  endfunction

  // Second feedback tap t of x^n + x^t + 1.
  function automatic logic [4:0] pn_tap(input logic [3:0] sel);
    case (sel)
      PN9:     return 5'd5;
      PN11:    return 5'd9;
      PN15:    return 5'd14;
      PN20:    return 5'd3;
      PN23:    return 5'd18;
      PN31:    return 5'd28;
      default: return 5'd6;
    endcase
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Received serial bit stream: one bit per bit_valid strobe, no backpressure.
// The source drives through master, the checker samples through slave.
interface prbs_checker_if;
  logic bit_in;
  logic bit_valid;

  modport master (output bit_in, output bit_valid);
  modport slave  (input bit_in, input bit_valid);
endinterface

// File: rtl/prbs_chk_lfsr.sv
// Local Fibonacci LFSR for the checker; pred is combinational from the register.
// Shifts once per shift_en (1 cycle); no backpressure.
module prbs_chk_lfsr
  import prbs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        sel,
  input  logic              load_rx,
  input  logic              shift_en,
  input  logic              rx_bit,
  output logic              pred,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [4:0]        order_m1;
  logic [4:0]        tap_m1;

  always_comb begin
    order_m1 = pn_order(sel) - 5'd1;
    tap_m1   = pn_tap(sel) - 5'd1;
    pred     = lfsr_q[order_m1] ^ lfsr_q[tap_m1];
    lfsr_d   = lfsr_q;
    // Bits above the polynomial order keep shifting but never feed pred.
    if (shift_en) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], (load_rx ? rx_bit : pred)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-seeding LFSR, SEED/VERIFY/LOCKED FSM, BER counters; PRBS_CHK_POLARITY_EN adds invert_in.
// Status/counters update 1 cycle after each bit_valid; no backpressure, a bit every cycle is accepted.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_WIN = 128,
  parameter int UNLOCK_ERR = 16
) (
  input  logic              dac_clk,
  input  logic              reset_n,
  prbs_checker_if.slave     rx,
  input  logic [3:0]        prbs_pn_select_in,
  input  logic              clear_counters,
`ifdef PRBS_CHK_POLARITY_EN
  input  logic              invert_in,
  output logic              polarity_inv_dbg,
`endif
  output logic              locked,
  output logic [1:0]        sync_state,
  output logic              err_pulse,
  output logic [31:0]       bit_count,
  output logic [31:0]       err_count,
  output logic [LFSR_W-1:0] lfsr_state_debug
);

  localparam int WIN_W = $clog2(UNLOCK_WIN + 1);

  sync_state_e       state_q, state_d;
  logic [4:0]        fill_q, fill_d;
  logic [7:0]        good_q, good_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]  win_err_q, win_err_d;
  logic [31:0]       bit_count_q, bit_count_d;
  logic [31:0]       err_count_q, err_count_d;
  logic              err_pulse_q, err_pulse_d;
  logic [3:0]        sel_prev_q, sel_prev_d;

  logic              rx_bit;
  logic              pred;
  logic              mismatch;
  logic              sel_chg;
  logic              bit_en;
  logic [4:0]        order;
  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-1:0] seed_mask;
  logic              seed_nz;

`ifdef PRBS_CHK_POLARITY_EN
  logic pol_q, pol_d;
  assign rx_bit = rx.bit_in ^ invert_in;
  assign pol_d  = invert_in;

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      pol_q <= 1'b0;
    end else begin
      pol_q <= pol_d;
    end
  end

  assign polarity_inv_dbg = pol_q;
`else
  assign rx_bit = rx.bit_in;
`endif

  // A select change drops the bit offered in that cycle; the stream restarts seeding.
  assign sel_chg = (prbs_pn_select_in != sel_prev_q);
  assign bit_en  = rx.bit_valid && !sel_chg;

  prbs_chk_lfsr u_lfsr (
    .clk      (dac_clk),
    .rst_n    (reset_n),
    .sel      (prbs_pn_select_in),
    .load_rx  (state_q == ST_SEED),
    .shift_en (bit_en),
    .rx_bit   (rx_bit),
    .pred     (pred),
    .state    (lfsr_state)
  );

  always_comb begin
    order     = pn_order(prbs_pn_select_in);
    mismatch  = rx_bit ^ pred;
    seed_mask = (LFSR_W'(1) << order) - LFSR_W'(1);
    // Seed validity is judged on the register contents after this bit shifts in.
    seed_nz   = |({lfsr_state[LFSR_W-2:0], rx_bit} & seed_mask);

    state_d     = state_q;
    fill_d      = fill_q;
    good_d      = good_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    sel_prev_d  = prbs_pn_select_in;

    if (sel_chg) begin
      state_d   = ST_SEED;
      fill_d    = '0;
      good_d    = '0;
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (bit_en) begin
      case (state_q)
        ST_SEED: begin
          if (fill_q + 5'd1 == order) begin
            fill_d = '0;
            if (seed_nz) begin
              state_d = ST_VERIFY;
              good_d  = '0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_d = ST_SEED;
            fill_d  = '0;
          end else if (good_q + 8'd1 == 8'(LOCK_CNT)) begin
            state_d   = ST_LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (bit_count_q != '1) begin
            bit_count_d = bit_count_q + 32'd1;
          end
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 32'd1;
            end
          end
          // Error threshold beats the window-end clear in the same cycle.
          if (mismatch && (win_err_q + WIN_W'(1) == WIN_W'(UNLOCK_ERR))) begin
            state_d   = ST_SEED;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q + WIN_W'(1) == WIN_W'(UNLOCK_WIN)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_q + WIN_W'(mismatch);
          end
        end
        default: begin
          state_d = ST_SEED;
          fill_d  = '0;
        end
      endcase
    end

    if (clear_counters) begin
      bit_count_d = '0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SEED;
      fill_q      <= '0;
      good_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      sel_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      sel_prev_q  <= sel_prev_d;
    end
  end

  assign locked           = (state_q == ST_LOCKED);
  assign sync_state       = state_q;
  assign err_pulse        = err_pulse_q;
  assign bit_count        = bit_count_q;
  assign err_count        = err_count_q;
  assign lfsr_state_debug = lfsr_state;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a history-queue reference model checked every cycle.
module tb_prbs_checker;

  localparam int LOCK_CNT   = 64;
  localparam int UNLOCK_WIN = 128;
  localparam int UNLOCK_ERR = 16;

  logic        dac_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        clr = 1'b0;
  logic        locked;
  logic [1:0]  sync_state;
  logic        err_pulse;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic [30:0] lfsr_dbg;
`ifdef PRBS_CHK_POLARITY_EN
  logic        invert_in = 1'b0;
  logic        pol_dbg;
`endif

  prbs_checker_if rx ();

  prbs_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_WIN (UNLOCK_WIN),
    .UNLOCK_ERR (UNLOCK_ERR)
  ) dut (
    .dac_clk           (dac_clk),
    .reset_n           (reset_n),
    .rx                (rx),
    .prbs_pn_select_in (sel),
    .clear_counters    (clr),
`ifdef PRBS_CHK_POLARITY_EN
    .invert_in         (invert_in),
    .polarity_inv_dbg  (pol_dbg),
`endif
    .locked            (locked),
    .sync_state        (sync_state),
    .err_pulse         (err_pulse),
    .bit_count         (bit_count),
    .err_count         (err_count),
    .lfsr_state_debug  (lfsr_dbg)
  );

  always #5 dac_clk = ~dac_clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  int ord_t [7] = '{7, 9, 11, 15, 20, 23, 31};
  int tap_t [7] = '{6, 5, 9, 14, 3, 18, 28};

  // Reference model: hist holds the bits the local LFSR has taken in, newest first.
  int          m_st, m_fill, m_good, m_wcnt, m_werr;
  logic [31:0] m_bits, m_errs;
  bit          m_pulse;
  logic [3:0]  m_sel_prev;
  bit          hist[$];

  // Stream source: all-ones seed, then b[k] = b[k-n] ^ b[k-t]; newest first.
  bit gen[$];
  int gsel;
  int g_emitted;

  function automatic int sidx(input logic [3:0] s);
    return (s > 4'd6) ? 0 : int'(s);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_good = 0; m_wcnt = 0; m_werr = 0;
    m_bits = '0; m_errs = '0; m_pulse = 0; m_sel_prev = 4'd0;
    hist.delete();
    repeat (31) hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic [3:0] s, input bit b, input bit v, input bit c);
    int k, n, t;
    bit p, mis, nz;
    k = sidx(s); n = ord_t[k]; t = tap_t[k];
    m_pulse = 0;
    if (s != m_sel_prev) begin
      m_st = 0; m_fill = 0; m_wcnt = 0; m_werr = 0;
    end else if (v) begin
      p   = hist[n-1] ^ hist[t-1];
      mis = b ^ p;
      if (m_st == 0) begin
        hist.push_front(b); void'(hist.pop_back());
        m_fill++;
        if (m_fill == n) begin
          m_fill = 0;
          nz = 0;
          for (int i = 0; i < n; i++) nz |= hist[i];
          if (nz) begin m_st = 1; m_good = 0; end
        end
      end else begin
        hist.push_front(p); void'(hist.pop_back());
        if (m_st == 1) begin
          if (mis) begin
            m_st = 0; m_fill = 0;
          end else begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_st = 2; m_wcnt = 0; m_werr = 0; end
          end
        end else begin
          if (m_bits != 32'hFFFF_FFFF) m_bits++;
          m_wcnt++;
          if (mis) begin
            if (m_errs != 32'hFFFF_FFFF) m_errs++;
            m_pulse = 1;
            m_werr++;
          end
          if (m_werr == UNLOCK_ERR) begin
            m_st = 0; m_fill = 0; m_wcnt = 0; m_werr = 0;
          end else if (m_wcnt == UNLOCK_WIN) begin
            m_wcnt = 0; m_werr = 0;
          end
        end
      end
    end
    m_sel_prev = s;
    if (c) begin m_bits = '0; m_errs = '0; end
  endtask

  task automatic compare_all();
    logic [30:0] e;
    for (int i = 0; i < 31; i++) e[i] = hist[i];
    chk("sync_state", 64'(sync_state), 64'(m_st));
    chk("locked", 64'(locked), 64'(m_st == 2));
    chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
    chk("bit_count", 64'(bit_count), 64'(m_bits));
    chk("err_count", 64'(err_count), 64'(m_errs));
    chk("lfsr", 64'(lfsr_dbg), 64'(e));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick(input bit v, input bit b, input bit c);
    rx.bit_valid = v; rx.bit_in = b; clr = c;
    @(posedge dac_clk);
    model_step(sel, b, v, c);
    @(negedge dac_clk);
    compare_all();
    if (err_pulse) pulses++;
    rx.bit_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic gen_reset();
    gen.delete();
    g_emitted = 0;
  endtask

  task automatic gen_bit(output bit b);
    int n, t;
    n = ord_t[gsel]; t = tap_t[gsel];
    if (g_emitted < n) b = 1'b1;
    else               b = gen[n-1] ^ gen[t-1];
    gen.push_front(b);
    if (gen.size() > 32) void'(gen.pop_back());
    g_emitted++;
  endtask

  task automatic send(input int cnt, input bit inv);
    bit b;
    for (int i = 0; i < cnt; i++) begin
      gen_bit(b);
      tick(1'b1, b ^ inv, 1'b0);
    end
  endtask

  task automatic do_reset(input logic [3:0] s);
    reset_n = 1'b0; sel = s; rx.bit_valid = 1'b0; rx.bit_in = 1'b0; clr = 1'b0;
    @(negedge dac_clk);
    @(negedge dac_clk);
    model_reset();
    compare_all();
    chk("rst_lfsr_zero", 64'(lfsr_dbg), 64'd0);
    reset_n = 1'b1;
    gen_reset();
    gsel = sidx(s);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [13:0] pre;
    bit          first [14];
    bit          b;
    logic [13:0] wrap;

    rx.bit_valid = 1'b0;
    rx.bit_in    = 1'b0;

    // Pin the stream source: PN7 from all-ones starts 1111111 000000 1 and repeats every 127 bits.
    gsel = 0; gen_reset(); pre = '0; wrap = '0;
    for (int i = 0; i < 141; i++) begin
      gen_bit(b);
      if (i < 14) begin pre = {pre[12:0], b}; first[i] = b; end
      if (i >= 127) wrap = {wrap[12:0], b ^ first[i-127]};
    end
    chk("pn7_prefix", 64'(pre), 64'(14'b11111110000001));
    chk("pn7_period", 64'(wrap), 64'd0);

    // Clean lock on PN7.
    do_reset(4'd0);
    send(7, 1'b0);
    chk("pn7_verify_after_7", 64'(sync_state), 64'd1);
    chk("pn7_lfsr_seed", 64'(lfsr_dbg), 64'h7F);
    send(63, 1'b0);
    chk("pn7_not_locked_70", 64'(locked), 64'd0);
    send(1, 1'b0);
    chk("pn7_locked_71", 64'(locked), 64'd1);
    send(1000, 1'b0);
    chk("pn7_bits_1000", 64'(bit_count), 64'd1000);
    chk("pn7_errs_0", 64'(err_count), 64'd0);

    // PN23: three isolated errors, with idle gaps in the stream.
    do_reset(4'd5);
    send(23 + 64, 1'b0);
    chk("pn23_locked", 64'(locked), 64'd1);
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 49) tick(1'b0, 1'b0, 1'b0);
      send(1, (i == 100) || (i == 300) || (i == 500));
    end
    chk("pn23_pulses", 64'(pulses), 64'd3);
    chk("pn23_errs", 64'(err_count), 64'd3);
    chk("pn23_bits", 64'(bit_count), 64'd600);
    chk("pn23_still_locked", 64'(locked), 64'd1);

    // PN15: 16 errors inside one window drop lock, then relock.
    do_reset(4'd3);
    send(15 + 64, 1'b0);
    chk("pn15_locked", 64'(locked), 64'd1);
    send(15, 1'b1);
    chk("pn15_locked_after_15_errs", 64'(locked), 64'd1);
    send(1, 1'b1);
    chk("pn15_seed_after_16_errs", 64'(sync_state), 64'd0);
    chk("pn15_errs", 64'(err_count), 64'd16);
    send(15 + 64, 1'b0);
    chk("pn15_relock", 64'(locked), 64'd1);

    // PN31: an all-zero seed is rejected, then a real stream locks.
    do_reset(4'd6);
    for (int i = 0; i < 31; i++) tick(1'b1, 1'b0, 1'b0);
    chk("pn31_zero_seed", 64'(sync_state), 64'd0);
    send(31, 1'b0);
    chk("pn31_verify", 64'(sync_state), 64'd1);
    send(64, 1'b0);
    chk("pn31_locked", 64'(locked), 64'd1);

    // PN9: clear_counters wins over a counted bit; select change reseeds and holds counters.
    do_reset(4'd1);
    send(9 + 64, 1'b0);
    send(500, 1'b0);
    chk("pn9_bits_500", 64'(bit_count), 64'd500);
    gen_bit(b);
    tick(1'b1, b, 1'b1);
    chk("pn9_clear", 64'(bit_count), 64'd0);
    send(10, 1'b0);
    chk("pn9_bits_10", 64'(bit_count), 64'd10);
    sel = 4'd2;
    tick(1'b0, 1'b0, 1'b0);
    chk("sel_chg_seed", 64'(sync_state), 64'd0);
    chk("sel_chg_bits_held", 64'(bit_count), 64'd10);
    gsel = 2; gen_reset();
    send(11 + 64, 1'b0);
    chk("pn11_locked", 64'(locked), 64'd1);

    // Asynchronous reset while locked, away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_locked", 64'(locked), 64'd0);
    chk("arst_state", 64'(sync_state), 64'd0);
    chk("arst_bits", 64'(bit_count), 64'd0);
    chk("arst_pulse", 64'(err_pulse), 64'd0);
    chk("arst_lfsr", 64'(lfsr_dbg), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
